// File: rtl/axis_diff_filter_if.sv
// AXI4-Stream handshake bundle used on both sides of the differentiator.
// The master side drives valid/data; the slave side drives ready.
interface axis_diff_filter_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_diff_filter.sv
// Pipelined AXI4-Stream differentiator with four run-time modes and output saturation.
// Stage 1 registers the unshifted full-precision sum; stage 2 shifts, clamps and holds the output.
module axis_diff_filter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [1:0]             mode,
  input  logic                   clear,
  input  logic                   sat_clear,
  axis_diff_filter_if.slave      S_AXIS,
  axis_diff_filter_if.master     M_AXIS,
  output logic [COUNT_WIDTH-1:0] sat_count
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned RW = W + 7;

  typedef logic signed [RW-1:0] raw_t;

  localparam raw_t C31    = raw_t'(31);
  localparam raw_t C6     = raw_t'(6);
  localparam raw_t SatMax = raw_t'({1'b0, {(W-1){1'b1}}});
  localparam raw_t SatMin = -SatMax - raw_t'(1);

  // hist_q[0] is the most recently accepted sample, i.e. x[n-1] relative to the incoming one.
  logic [3:0][W-1:0] hist_q, hist_d;

  logic                   adv, accept;
  raw_t                   xs, p0, p1, p2, p3, d1, d2, raw_d;
  raw_t                   raw_q, res;
  logic [1:0]             mode_q;
  logic                   v1_q;
  logic                   sat_hi, sat_lo, sat_hit;
  logic [W-1:0]           sat_val;
  logic                   out_valid_q;
  logic [W-1:0]           out_data_q;
  logic [COUNT_WIDTH-1:0] sat_count_q;

  assign adv            = !out_valid_q || M_AXIS.tready;
  assign S_AXIS.tready  = adv && !areset;
  assign accept         = S_AXIS.tvalid && S_AXIS.tready;
  assign M_AXIS.tvalid  = out_valid_q;
  assign M_AXIS.tdata   = out_data_q;
  assign sat_count      = sat_count_q;

  always_comb begin
    hist_d = hist_q;
    if (accept) begin
      hist_d[0] = S_AXIS.tdata;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
    end
    if (clear) begin
      hist_d[1] = '0;
      hist_d[2] = '0;
      hist_d[3] = '0;
      if (!accept) hist_d[0] = '0;
    end
  end

  // A clear coincident with accept computes the new sample against zero history.
  always_comb begin
    xs = raw_t'($signed(S_AXIS.tdata));
    p0 = clear ? '0 : raw_t'($signed(hist_q[0]));
    p1 = clear ? '0 : raw_t'($signed(hist_q[1]));
    p2 = clear ? '0 : raw_t'($signed(hist_q[2]));
    p3 = clear ? '0 : raw_t'($signed(hist_q[3]));
    d1 = p0 - p2;
    d2 = p3 - xs;
    case (mode)
      2'd0:    raw_d = xs;
      2'd1:    raw_d = xs - p0;
      2'd2:    raw_d = xs - p1;
      default: raw_d = d1 * C31 + d2 * C6;
    endcase
  end

  always_comb begin
    case (mode_q)
      2'd2:    res = raw_q >>> 1;
      2'd3:    res = raw_q >>> 5;
      default: res = raw_q;
    endcase
    sat_hi  = res > SatMax;
    sat_lo  = res < SatMin;
    sat_hit = sat_hi || sat_lo;
    if (sat_hi) begin
      sat_val = {1'b0, {(W-1){1'b1}}};
    end else if (sat_lo) begin
      sat_val = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_val = res[W-1:0];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hist_q <= '0;
    end else if (adv || clear) begin
      hist_q <= hist_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1_q   <= 1'b0;
      raw_q  <= '0;
      mode_q <= 2'd0;
    end else if (adv) begin
      v1_q <= accept;
      if (accept) begin
        raw_q  <= raw_d;
        mode_q <= mode;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      out_valid_q <= v1_q;
      if (v1_q) out_data_q <= sat_val;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sat_count_q <= '0;
    end else if (sat_clear) begin
      sat_count_q <= '0;
    end else if (adv && v1_q && sat_hit && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_diff_filter.sv
// Scoreboard bench for axis_diff_filter: a reference model queues expected outputs on accept,
// a monitor pops and compares them on each output handshake.
module tb_axis_diff_filter;

  typedef struct {
    logic [15:0] data;
    bit          sat;
    int          cyc;
  } exp_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        clear = 1'b0;
  logic        sat_clear = 1'b0;
  logic [15:0] sat_count;

  axis_diff_filter_if #(.DATA_WIDTH(16)) s_if ();
  axis_diff_filter_if #(.DATA_WIDTH(16)) m_if ();

  axis_diff_filter #(
    .DATA_WIDTH (16),
    .COUNT_WIDTH(16)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .mode     (mode),
    .clear    (clear),
    .sat_clear(sat_clear),
    .S_AXIS   (s_if),
    .M_AXIS   (m_if),
    .sat_count(sat_count)
  );

  always #5 aclk = ~aclk;

  exp_t q[$];
  int   mh[4];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_sat = 0;
  bit   lat_check = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void model(input int x, input int md, input int h0, input int h1,
                                input int h2, input int h3, output logic [15:0] d, output bit s);
    int r;
    case (md)
      0:       r = x;
      1:       r = x - h0;
      2:       r = (x - h1) >>> 1;
      default: r = (-6 * x + 31 * h0 - 31 * h2 + 6 * h3) >>> 5;
    endcase
    s = 0;
    if (r > 32767) begin
      r = 32767;
      s = 1;
    end else if (r < -32768) begin
      r = -32768;
      s = 1;
    end
    d = 16'(r);
  endfunction

  // Reference model: history shifts on accept, clear zeroes it.
  always @(negedge aclk) begin
    if (!areset) begin
      if (s_if.tvalid && s_if.tready) begin
        exp_t e;
        int   x;
        x = int'($signed(s_if.tdata));
        if (clear) begin
          mh[0] = 0; mh[1] = 0; mh[2] = 0; mh[3] = 0;
        end
        model(x, int'(mode), mh[0], mh[1], mh[2], mh[3], e.data, e.sat);
        e.cyc = cyc;
        q.push_back(e);
        mh[3] = mh[2]; mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = x;
      end else if (clear) begin
        mh[0] = 0; mh[1] = 0; mh[2] = 0; mh[3] = 0;
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset && m_if.tvalid && m_if.tready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d, required no output", $signed(m_if.tdata));
      end else begin
        exp_t e;
        e = q.pop_front();
        if (m_if.tdata !== e.data) begin
          errors++;
          $display("FAIL output_data: got %0d, required %0d", $signed(m_if.tdata),
                   $signed(e.data));
        end
        if (e.sat && exp_sat < 65535) exp_sat++;
        if (lat_check) begin
          checks++;
          if (cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 2", cyc - e.cyc);
          end
        end
      end
    end
  end

  task automatic send(input int x, input int md, input bit clr);
    bit acc;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 16'(x);
    mode        = 2'(md);
    clear       = clr;
    acc         = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge aclk);
      acc = s_if.tready;
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b0;
    clear       = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no accept, required accept of %0d", x);
    end
  endtask

  task automatic drain(output bit ok);
    m_if.tready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
    ok = (q.size() == 0) && !m_if.tvalid;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge aclk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_drain(input string name);
    bit ok;
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending outputs, required 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    areset      = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checks += 4;
    if (s_if.tready !== 1'b0) begin
      errors++; $display("FAIL reset_s_tready: got %b, required 0", s_if.tready);
    end
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_m_tvalid: got %b, required 0", m_if.tvalid);
    end
    if (m_if.tdata !== 16'd0) begin
      errors++; $display("FAIL reset_m_tdata: got %0d, required 0", m_if.tdata);
    end
    if (sat_count !== 16'd0) begin
      errors++; $display("FAIL reset_sat_count: got %0d, required 0", sat_count);
    end
    areset = 1'b0;
    #1;
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++; $display("FAIL release_s_tready: got %b, required 1", s_if.tready);
    end
  endtask

  task automatic test_mode1_step();
    lat_check = 1;
    send(100, 1, 0);
    send(100, 1, 0);
    send(100, 1, 0);
    send(-50, 1, 0);
    check_drain("mode1_step");
    lat_check = 0;
  endtask

  task automatic test_mode3_ramp();
    for (int n = 0; n < 10; n++) send(32 * n, 3, n == 0);
    check_drain("mode3_ramp");
  endtask

  task automatic test_saturation();
    send(-32768, 1, 1);
    send(32767, 1, 0);
    check_drain("sat_mode1");
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      errors++; $display("FAIL sat_count_mode1: got %0d, required %0d", sat_count, exp_sat);
    end
    send(-32768, 2, 1);
    send(0, 2, 0);
    send(32767, 2, 0);
    check_drain("sat_mode2");
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      errors++; $display("FAIL sat_count_mode2: got %0d, required %0d", sat_count, exp_sat);
    end
    send(32767, 3, 1);
    send(-32768, 3, 0);
    send(0, 3, 0);
    send(32767, 3, 0);
    send(-32768, 3, 0);
    check_drain("sat_mode3");
    checks++;
    if (sat_count !== 16'(exp_sat)) begin
      errors++; $display("FAIL sat_count_mode3: got %0d, required %0d", sat_count, exp_sat);
    end
    sat_clear = 1'b1;
    @(posedge aclk);
    #1;
    sat_clear = 1'b0;
    exp_sat   = 0;
    checks++;
    if (sat_count !== 16'd0) begin
      errors++; $display("FAIL sat_clear: got %0d, required 0", sat_count);
    end
  endtask

  task automatic test_backpressure();
    fork
      begin
        for (int n = 1; n <= 30; n++) send(n, 1, n == 1);
      end
      begin
        logic [15:0] held;
        repeat (8) @(posedge aclk);
        #1;
        m_if.tready = 1'b0;
        held = m_if.tdata;
        for (int i = 0; i < 5; i++) begin
          @(posedge aclk);
          #1;
          checks += 3;
          if (m_if.tvalid !== 1'b1) begin
            errors++; $display("FAIL stall_valid: got %b, required 1", m_if.tvalid);
          end
          if (m_if.tdata !== held) begin
            errors++; $display("FAIL stall_data: got %0d, required %0d", m_if.tdata, held);
          end
          if (s_if.tready !== 1'b0) begin
            errors++; $display("FAIL stall_s_tready: got %b, required 0", s_if.tready);
          end
        end
        m_if.tready = 1'b1;
      end
    join
    check_drain("backpressure");
  endtask

  task automatic test_clear_mode_change();
    pulse_clear();
    send(10, 1, 0);
    send(20, 1, 0);
    send(25, 1, 1);
    send(7, 0, 0);
    check_drain("clear_mode");
  endtask

  task automatic test_reset_midstream();
    m_if.tready = 1'b0;
    pulse_clear();
    send(5, 1, 0);
    send(6, 1, 0);
    checks++;
    if (m_if.tvalid !== 1'b1) begin
      errors++; $display("FAIL midstream_valid: got %b, required 1", m_if.tvalid);
    end
    #3;
    areset = 1'b1;
    #1;
    checks += 2;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL async_reset_valid: got %b, required 0", m_if.tvalid);
    end
    if (s_if.tready !== 1'b0) begin
      errors++; $display("FAIL async_reset_s_tready: got %b, required 0", s_if.tready);
    end
    q.delete();
    mh[0] = 0; mh[1] = 0; mh[2] = 0; mh[3] = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset      = 1'b0;
    m_if.tready = 1'b1;
    send(40, 1, 0);
    check_drain("after_reset");
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_mode1_step();
    test_mode3_ramp();
    test_saturation();
    test_backpressure();
    test_clear_mode_change();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required completion");
    $fatal(1);
  end

endmodule
